time_set_ctrl: RTL and testbench

Mode and set-up controller for the century clock's counter chain (second, minute, hour, day, month, year). In RUN it forwards the 1 Hz tick and the counter carries as the enables of the next counter. In a SET state it freezes timekeeping and steers debounced push-button increments, with auto-repeat, into exactly one selected field. It sits between the button/tick front end and the counter enables, and drives the per-field blanking used by the display drivers.

---
 rtl/time_set_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// Mode and set-up controller for the clock's counter chain.
// RUN forwards the 1 Hz tick and counter carries as the next counter's enables.
// SET states freeze timekeeping. They steer button increments, with
// auto-repeat, into one selected field and blink that field on the display.
module time_set_ctrl #(
  parameter int HOLD_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 12_500_000,
  parameter int TIMEOUT_S  = 30,
  parameter int CNT_W      = 26
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       cy_sec,
  input  logic       cy_min,
  input  logic       cy_hour,
  input  logic       cy_day,
  input  logic       cy_mon,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       inc_hour,
  output logic       inc_day,
  output logic       inc_mon,
  output logic       inc_year,
  output logic       clr_sec,
  output logic [5:0] blank,
  output logic       setting
);

  localparam int TO_W = $clog2(TIMEOUT_S + 1);

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_SET_HOUR = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_SET_DAY  = 3'd3,
    ST_SET_MON  = 3'd4,
    ST_SET_YEAR = 3'd5
  } state_t;

  state_t           state_r, state_nxt_s;
  logic             mode_prev_r, inc_prev_r, hist_vld_r;
  logic             set_pulse_r, set_pulse_nxt_s;
  logic             clr_sec_r;
  logic             blink_ph_r, blink_nxt_s;
  logic [TO_W-1:0]  to_cnt_r, to_cnt_nxt_s;
  logic             rep_act_r, rep_act_nxt_s;
  logic             rep_ph_r, rep_ph_nxt_s;
  logic [CNT_W-1:0] rep_cnt_r, rep_cnt_nxt_s, rep_lim_s;
  logic [5:0]       blank_r;
  logic             setting_r;
  logic             mode_rise_s, inc_rise_s, in_set_s, run_s;
  logic             timeout_s, state_chg_s;

  // Display mask of the field a SET state edits.
  function automatic logic [5:0] field_mask(input state_t st);
    case (st)
      ST_SET_HOUR: field_mask = 6'b000100;
      ST_SET_MIN:  field_mask = 6'b000010;
      ST_SET_DAY:  field_mask = 6'b001000;
      ST_SET_MON:  field_mask = 6'b010000;
      ST_SET_YEAR: field_mask = 6'b100000;
      default:     field_mask = 6'b000000;
    endcase
  endfunction

  // Edges are ignored until one post-reset sample exists, so a held button is not an edge.
  assign mode_rise_s = hist_vld_r & btn_mode & ~mode_prev_r;
  assign inc_rise_s  = hist_vld_r & btn_inc & ~inc_prev_r;
  assign run_s       = (state_r == ST_RUN);
  assign in_set_s    = ~run_s;
  // A button edge on the same tick restarts the idle count instead of timing out.
  assign timeout_s   = in_set_s & tick_1hz & ~inc_rise_s &
                       (to_cnt_r == TO_W'(TIMEOUT_S - 1));
  assign state_chg_s = (state_nxt_s != state_r);
  assign rep_lim_s   = rep_ph_r ? CNT_W'(REPEAT_CYC) : CNT_W'(HOLD_CYC);

  // Next state: mode edge advances the cycle and takes priority over timeout.
  always_comb begin
    state_nxt_s = state_r;
    if (mode_rise_s) begin
      case (state_r)
        ST_RUN:      state_nxt_s = ST_SET_HOUR;
        ST_SET_HOUR: state_nxt_s = ST_SET_MIN;
        ST_SET_MIN:  state_nxt_s = ST_SET_DAY;
        ST_SET_DAY:  state_nxt_s = ST_SET_MON;
        ST_SET_MON:  state_nxt_s = ST_SET_YEAR;
        ST_SET_YEAR: state_nxt_s = ST_RUN;
        default:     state_nxt_s = ST_RUN;
      endcase
    end else if (timeout_s) begin
      state_nxt_s = ST_RUN;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Idle timeout and blink phase; both restart whenever the mode changes.
  always_comb begin
    to_cnt_nxt_s = to_cnt_r;
    blink_nxt_s  = blink_ph_r;
    if (!in_set_s || state_chg_s || mode_rise_s || inc_rise_s) begin
      to_cnt_nxt_s = {TO_W{1'b0}};
    end else if (tick_1hz) begin
      to_cnt_nxt_s = to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_nxt_s = to_cnt_r;
    end
    if (!in_set_s || state_chg_s) begin
      blink_nxt_s = 1'b0;
    end else if (tick_1hz) begin
      blink_nxt_s = ~blink_ph_r;
    end else begin
      blink_nxt_s = blink_ph_r;
    end
  end

  // Set pulse generation: edge pulse, then first repeat after HOLD_CYC, then every REPEAT_CYC.
  always_comb begin
    set_pulse_nxt_s = 1'b0;
    rep_act_nxt_s   = rep_act_r;
    rep_ph_nxt_s    = rep_ph_r;
    rep_cnt_nxt_s   = rep_cnt_r;
    if (!in_set_s || state_chg_s || !btn_inc) begin
      rep_act_nxt_s = 1'b0;
      rep_ph_nxt_s  = 1'b0;
      rep_cnt_nxt_s = {CNT_W{1'b0}};
    end else if (inc_rise_s) begin
      set_pulse_nxt_s = 1'b1;
      rep_act_nxt_s   = 1'b1;
      rep_ph_nxt_s    = 1'b0;
      rep_cnt_nxt_s   = CNT_W'(1);
    end else if (rep_act_r) begin
      if (rep_cnt_r == rep_lim_s) begin
        set_pulse_nxt_s = 1'b1;
        rep_ph_nxt_s    = 1'b1;
        rep_cnt_nxt_s   = CNT_W'(1);
      end else begin
        rep_cnt_nxt_s = rep_cnt_r + CNT_W'(1);
      end
    end else begin
      set_pulse_nxt_s = 1'b0;
    end
  end

  // State register and button history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_RUN;
      mode_prev_r <= 1'b0;
      inc_prev_r  <= 1'b0;
      hist_vld_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      mode_prev_r <= btn_mode;
      inc_prev_r  <= btn_inc;
      hist_vld_r  <= 1'b1;
    end
  end

  // Timers, repeat counter and registered pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_r    <= {TO_W{1'b0}};
      blink_ph_r  <= 1'b0;
      rep_act_r   <= 1'b0;
      rep_ph_r    <= 1'b0;
      rep_cnt_r   <= {CNT_W{1'b0}};
      set_pulse_r <= 1'b0;
      clr_sec_r   <= 1'b0;
    end else begin
      to_cnt_r    <= to_cnt_nxt_s;
      blink_ph_r  <= blink_nxt_s;
      rep_act_r   <= rep_act_nxt_s;
      rep_ph_r    <= rep_ph_nxt_s;
      rep_cnt_r   <= rep_cnt_nxt_s;
      set_pulse_r <= set_pulse_nxt_s;
      clr_sec_r   <= run_s & (state_nxt_s == ST_SET_HOUR);
    end
  end

  // Display blanking and setting flag, aligned with the registered state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_r   <= 6'b000000;
      setting_r <= 1'b0;
    end else begin
      blank_r   <= blink_nxt_s ? field_mask(state_nxt_s) : 6'b000000;
      setting_r <= (state_nxt_s != ST_RUN);
    end
  end

  // RUN cascade is zero-latency; SET enables come only from the registered set pulse.
  assign inc_sec  = run_s & tick_1hz;
  assign inc_min  = run_s ? cy_sec  : (set_pulse_r & (state_r == ST_SET_MIN));
  assign inc_hour = run_s ? cy_min  : (set_pulse_r & (state_r == ST_SET_HOUR));
  assign inc_day  = run_s ? cy_hour : (set_pulse_r & (state_r == ST_SET_DAY));
  assign inc_mon  = run_s ? cy_day  : (set_pulse_r & (state_r == ST_SET_MON));
  assign inc_year = run_s ? cy_mon  : (set_pulse_r & (state_r == ST_SET_YEAR));
  assign clr_sec  = clr_sec_r;
  assign blank    = blank_r;
  assign setting  = setting_r;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed scenarios plus random
// stimulus, all compared against a behavioural model of the controller.
module tb_time_set_ctrl;

  localparam int HOLD   = 8;
  localparam int REPEAT = 3;
  localparam int TMO    = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic tick_1hz, btn_mode, btn_inc;
  logic cy_sec, cy_min, cy_hour, cy_day, cy_mon;
  logic inc_sec, inc_min, inc_hour, inc_day, inc_mon, inc_year;
  logic clr_sec, setting;
  logic [5:0] blank;

  int n_checks = 0;
  int n_errors = 0;

  // Model: mode index 0=RUN,1=HOUR,2=MIN,3=DAY,4=MON,5=YEAR
  int m_mode, m_idle, m_age;
  bit m_pulse, m_clr, m_blink, m_pm, m_pi, m_hv;
  int fld_bit[6] = '{0, 2, 1, 3, 4, 5};

  logic [13:0] obs;

  time_set_ctrl #(.HOLD_CYC(HOLD), .REPEAT_CYC(REPEAT), .TIMEOUT_S(TMO), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cy_sec(cy_sec), .cy_min(cy_min), .cy_hour(cy_hour), .cy_day(cy_day), .cy_mon(cy_mon),
    .inc_sec(inc_sec), .inc_min(inc_min), .inc_hour(inc_hour), .inc_day(inc_day),
    .inc_mon(inc_mon), .inc_year(inc_year), .clr_sec(clr_sec), .blank(blank), .setting(setting)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_idle = 0; m_age = -1;
    m_pulse = 0; m_clr = 0; m_blink = 0; m_pm = 0; m_pi = 0; m_hv = 0;
  endtask

  task automatic model_step();
    bit mr, ir, in_set, chg;
    int nm;
    mr = m_hv && btn_mode && !m_pm;
    ir = m_hv && btn_inc && !m_pi;
    in_set = (m_mode != 0);
    nm = m_mode;
    if (mr) nm = (m_mode + 1) % 6;
    else if (in_set && tick_1hz && !ir && (m_idle + 1 >= TMO)) nm = 0;
    chg = (nm != m_mode);
    if (!in_set || chg || mr || ir) m_idle = 0;
    else if (tick_1hz) m_idle++;
    // age = cycles since btn_inc was first sampled high in this SET state
    if (in_set && !chg && btn_inc) begin
      if (ir) m_age = 0;
      else if (m_age >= 0) m_age++;
      m_pulse = (m_age == 0) || (m_age >= HOLD && ((m_age - HOLD) % REPEAT) == 0);
    end else begin
      m_age = -1;
      m_pulse = 0;
    end
    m_clr = (m_mode == 0) && (nm == 1);
    if (!in_set || chg) m_blink = 0;
    else if (tick_1hz) m_blink = !m_blink;
    m_mode = nm;
    m_pm = btn_mode; m_pi = btn_inc; m_hv = 1;
  endtask

  function automatic logic [13:0] exp_vec();
    logic run;
    logic [5:0] iv, bl, one;
    run = (m_mode == 0);
    one = 6'd1;
    iv[0] = run & tick_1hz;
    iv[1] = run ? cy_sec  : (m_pulse && m_mode == 2);
    iv[2] = run ? cy_min  : (m_pulse && m_mode == 1);
    iv[3] = run ? cy_hour : (m_pulse && m_mode == 3);
    iv[4] = run ? cy_day  : (m_pulse && m_mode == 4);
    iv[5] = run ? cy_mon  : (m_pulse && m_mode == 5);
    bl = 6'd0;
    if (m_blink && !run) bl = one << fld_bit[m_mode];
    return {iv, m_clr, bl, !run};
  endfunction

  // One clock: drive inputs, compare at negedge, advance model at posedge.
  task automatic cyc(input logic t, input logic m, input logic i, input logic [4:0] cy);
    tick_1hz = t; btn_mode = m; btn_inc = i;
    {cy_mon, cy_day, cy_hour, cy_min, cy_sec} = cy;
    @(negedge clk);
    obs = {inc_year, inc_mon, inc_day, inc_hour, inc_min, inc_sec, clr_sec, blank, setting};
    check_eq("outs", 32'(obs), 32'(exp_vec()));
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic press_mode();
    cyc(1'b0, 1'b1, 1'b0, 5'd0);
    cyc(1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  logic [5:0] blank_tbl [6] = '{6'b000100, 6'b000010, 6'b001000, 6'b010000, 6'b100000, 6'b000000};
  logic [5:0] blink_tbl [4] = '{6'b001000, 6'b000000, 6'b001000, 6'b000000};

  initial begin
    int clr_cnt, day_cnt;
    logic [31:0] mask;
    logic r_m, r_i;
    reset_n = 1'b0;
    tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    {cy_mon, cy_day, cy_hour, cy_min, cy_sec} = 5'd0;
    model_reset();
    @(posedge clk); #1;
    cyc(1'b0, 1'b0, 1'b0, 5'd0);
    check_eq("reset_outs", 32'(obs), 32'd0);
    reset_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 5'd0);

    // RUN cascade
    cyc(1'b1, 1'b0, 1'b0, 5'b00001);
    check_eq("run_casc", 32'(obs[10:8]), 32'b011);

    // Mode walk
    clr_cnt = 0;
    for (int p = 0; p < 6; p++) begin
      cyc(1'b0, 1'b1, 1'b0, 5'd0);
      clr_cnt += int'(obs[7]);
      cyc(1'b1, 1'b0, 1'b0, 5'b11111);
      clr_cnt += int'(obs[7]);
      if (p < 5) check_eq("set_casc", 32'(obs[13:8]), 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 5'd0);
      clr_cnt += int'(obs[7]);
      check_eq("blank_field", 32'(obs[6:1]), 32'(blank_tbl[p]));
    end
    check_eq("clr_once", 32'(clr_cnt), 32'd1);

    // Increment isolation in SET_MON
    repeat (4) press_mode();
    cyc(1'b0, 1'b0, 1'b1, 5'b10000);
    cyc(1'b0, 1'b0, 1'b0, 5'b10000);
    check_eq("inc_mon_pulse", 32'(obs[13:12]), 32'b01);
    cyc(1'b0, 1'b0, 1'b0, 5'b10000);
    check_eq("inc_mon_width", 32'(obs[13:12]), 32'b00);

    // Auto-repeat in SET_HOUR
    repeat (3) press_mode();
    mask = 32'd0;
    for (int k = 0; k < 30; k++) begin
      cyc(1'b0, 1'b0, (k < 20) ? 1'b1 : 1'b0, 5'd0);
      if (obs[10]) mask[k] = 1'b1;
    end
    check_eq("rep_offsets", mask, 32'h0004_9202);

    // Collision then timeout
    press_mode();
    cyc(1'b0, 1'b1, 1'b1, 5'd0);
    cyc(1'b0, 1'b0, 1'b0, 5'd0);
    check_eq("coll_no_inc", 32'(obs[13:8]), 32'd0);
    for (int t = 0; t < 4; t++) begin
      cyc(1'b1, 1'b0, 1'b0, 5'd0);
      cyc(1'b0, 1'b0, 1'b0, 5'd0);
      check_eq("blink_tick", 32'(obs[6:1]), 32'(blink_tbl[t]));
    end
    check_eq("to_run", 32'(obs[0]), 32'd0);

    // Reset in SET_DAY with btn_inc held
    repeat (3) press_mode();
    cyc(1'b0, 1'b0, 1'b1, 5'd0);
    cyc(1'b0, 1'b0, 1'b1, 5'd0);
    reset_n = 1'b0;
    #1;
    check_eq("rst_setting", 32'(setting), 32'd0);
    check_eq("rst_blank", 32'(blank), 32'd0);
    model_reset();
    cyc(1'b0, 1'b0, 1'b1, 5'd0);
    cyc(1'b0, 1'b0, 1'b1, 5'd0);
    reset_n = 1'b1;
    day_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 5'd0);
      day_cnt += int'(obs[11]);
    end
    check_eq("rst_no_inc", 32'(day_cnt), 32'd0);
    check_eq("rst_run", 32'(obs[0]), 32'd0);

    // Random stimulus against the model
    r_m = 1'b0; r_i = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset_n = 1'b0;
        model_reset();
        cyc(1'b0, r_m, r_i, 5'd0);
        reset_n = 1'b1;
      end
      if ($urandom_range(0, 11) == 0) r_m = ~r_m;
      if ($urandom_range(0, 13) == 0) r_i = ~r_i;
      cyc(($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0, r_m, r_i, 5'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
